instr_fetch_mem: RTL
====================

Name: instr_fetch_mem

Overview:
- Instruction-memory responder on the other end of the CPU fetch interface: takes the CPU's PC and returns the 32-bit INSTRUCTION word.
- Program image is streamed in byte-wise through a valid/ready load port after reset.
- The CPU is held off (CPU_HOLD) until loading completes.
- Fetch reads are registered: one-cycle latency.

Parameters:
- DEPTH, 16, number of 32-bit instruction words stored.
- ADDR_W, 4, word-index width; DEPTH == 2**ADDR_W.
- FILL, 32'hFFFFFFFF, word returned for unloaded, out-of-range or misaligned fetches (undecoded opcode 0xFF).

Ports:
- CLK  in  1  single clock, posedge.
- RESET  in  1  asynchronous, active-low reset.
- LOAD_VALID  in  1  load byte present.
- LOAD_BYTE  in  8  load data.
- LOAD_LAST  in  1  qualifies the final byte of the image.
- LOAD_READY  out  1  block accepts a load byte.
- PC  in  32  CPU program counter (byte address).
- INSTRUCTION  out  32  fetched instruction word.
- INSTR_VALID  out  1  INSTRUCTION came from a loaded entry.
- CPU_HOLD  out  1  CPU must stay in reset/stall while high.
- WORD_COUNT  out  ADDR_W+1  number of words loaded.
- FAULT  out  1  sticky bad-fetch flag.

Behaviour:
- Reset asserted (RESET==0):
  - state=LOAD, byte index=0, WORD_COUNT=0, all per-entry valid bits=0.
  - INSTRUCTION=FILL, INSTR_VALID=0, CPU_HOLD=1, FAULT=0.
  - Any partial word is discarded; this also applies to a reset taken mid-load.
- States: LOAD, RUN. Leaving RUN requires reset.
- LOAD_READY = (state==LOAD), combinational. A transfer occurs on a posedge with LOAD_VALID & LOAD_READY.
- Word assembly is big-endian: byte index 0 goes to [31:24], index 1 to [23:16], index 2 to [15:8], index 3 to [7:0].
- On a transfer with index 3: write the word to mem[WORD_COUNT], set its valid bit, WORD_COUNT+1, index back to 0.
- LOAD_LAST on a transfer at index<3: remaining low bytes are padded with 0x00, the word is written and counted, state goes to RUN.
- LOAD_LAST at index 3: write, then state goes to RUN.
- Full: when a write makes WORD_COUNT==DEPTH, state goes to RUN in the same cycle, regardless of LOAD_LAST.
- LOAD_LAST with no transfer is ignored.
- CPU_HOLD = (state==LOAD); it deasserts the cycle after the last write.
- RUN fetch, every posedge:
  - idx = PC[ADDR_W+1:2].
  - Hit: PC[1:0]==0 and PC[31:ADDR_W+2]==0 and valid[idx]. Then INSTRUCTION<=mem[idx] and INSTR_VALID<=1.
  - Otherwise INSTRUCTION<=FILL and INSTR_VALID<=0.
- FAULT is set sticky on a RUN fetch that is misaligned or out-of-range (upper bits nonzero).
  - Exception: PC==32'hFFFFFFFC, the CPU's pre-reset vector, returns FILL without FAULT.
  - An aligned, in-range fetch of an unloaded entry returns FILL without FAULT.
- In LOAD, INSTRUCTION holds FILL and INSTR_VALID=0; PC is ignored.
- Latency: the INSTRUCTION for a given PC is visible after the next posedge. Memory and fetch are registered, with no combinational PC-to-INSTRUCTION path.
- WORD_COUNT saturates at DEPTH; LOAD_VALID is ignored in RUN.

Test Plan:
- Reset, then stream 00 01 02 05 / 01 03 01 02 with LAST on byte 8. Required: WORD_COUNT==2, CPU_HOLD falls. PC=0 returns 32'h00010205 with INSTR_VALID=1 one cycle later. PC=4 returns 32'h01030102.
- Stream 3 bytes AA BB CC with LAST on the third. Required: mem[0]==32'hAABBCC00, WORD_COUNT==1, state RUN.
- Stream 64 bytes with LOAD_VALID held high and no LAST. Required: RUN entered after byte 64, WORD_COUNT==16, LOAD_READY==0, byte 65 ignored.
- In RUN, load 2 words, then fetch:
  - PC=8 (unloaded) returns FILL, INSTR_VALID=0, FAULT=0.
  - PC=32'hFFFFFFFC returns FILL, FAULT=0.
  - PC=2 returns FILL, FAULT=1.
  - FAULT stays 1 on a later PC=0.
- Assert RESET low after 5 bytes, with RESET released on a non-edge. Required: outputs return to reset values immediately. Reload 4 bytes 11 22 33 44 with LAST: PC=0 returns 32'h11223344, WORD_COUNT==1.
- Drive LOAD_VALID with a random gap pattern. Required: bytes are taken only on cycles where VALID & READY, and the assembled words match the stream order.

Source files
------------

// File: rtl/instr_fetch_mem_if.sv
// instr_fetch_mem_if: load port and CPU fetch port of the instruction memory
interface instr_fetch_mem_if #(parameter int ADDR_W = 4);
   logic              LOAD_VALID;
   logic [7:0]        LOAD_BYTE;
   logic              LOAD_LAST;
   logic              LOAD_READY;
   logic [31:0]       PC;
   logic [31:0]       INSTRUCTION;
   logic              INSTR_VALID;
   logic              CPU_HOLD;
   logic [ADDR_W:0]   WORD_COUNT;
   logic              FAULT;
   modport master (
      output LOAD_VALID, LOAD_BYTE, LOAD_LAST, PC,
      input  LOAD_READY, INSTRUCTION, INSTR_VALID, CPU_HOLD, WORD_COUNT, FAULT
   );
   modport slave (
      input  LOAD_VALID, LOAD_BYTE, LOAD_LAST, PC,
      output LOAD_READY, INSTRUCTION, INSTR_VALID, CPU_HOLD, WORD_COUNT, FAULT
   );
endinterface

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-streamed program loader feeding a registered instruction fetch port
module instr_fetch_mem #(
   parameter int          DEPTH  = 16,
   parameter int          ADDR_W = 4,
   parameter logic [31:0] FILL   = 32'hFFFF_FFFF
) (
   input logic              CLK,
   input logic              RESET,
   instr_fetch_mem_if.slave bus
);
   typedef enum logic {LOAD, RUN} state_t;
   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [DEPTH-1:0]    valid_q, valid_d;
   logic [31:0]         part_q, part_d;
   logic [31:0]         instr_q, instr_d;
   logic                instr_valid_q, instr_valid_d;
   logic                fault_q, fault_d;
   logic [31:0]         mem_q [DEPTH];
   logic                xfer, wr_en, aligned, in_range, hit;
   logic [31:0]         wr_word;
   logic [ADDR_W-1:0]   wr_addr, rd_addr;
   assign bus.LOAD_READY  = state_q == LOAD;
   assign bus.CPU_HOLD    = state_q == LOAD;
   assign bus.WORD_COUNT  = count_q;
   assign bus.INSTRUCTION = instr_q;
   assign bus.INSTR_VALID = instr_valid_q;
   assign bus.FAULT       = fault_q;
   // Big-endian word assembly, load sequencing and registered fetch decode
   always_comb begin
      xfer          = bus.LOAD_VALID && state_q == LOAD;
      wr_word       = part_q | ({24'd0, bus.LOAD_BYTE} << {~idx_q, 3'b000});
      wr_en         = xfer && (idx_q == 2'd3 || bus.LOAD_LAST);
      wr_addr       = count_q[ADDR_W-1:0];
      rd_addr       = bus.PC[ADDR_W+1:2];
      aligned       = bus.PC[1:0] == 2'b00;
      in_range      = bus.PC[31:ADDR_W+2] == '0;
      hit           = aligned && in_range && valid_q[rd_addr];
      state_d       = state_q;
      idx_d         = idx_q;
      part_d        = part_q;
      count_d       = count_q;
      valid_d       = valid_q;
      instr_d       = FILL;
      instr_valid_d = 1'b0;
      fault_d       = fault_q;
      if (xfer) begin
         idx_d  = idx_q + 2'd1;
         part_d = wr_word;
      end
      if (wr_en) begin
         idx_d            = 2'd0;
         part_d           = '0;
         count_d          = count_q + 1'b1;
         valid_d[wr_addr] = 1'b1;
         if (bus.LOAD_LAST || count_q + 1'b1 == FULL) state_d = RUN;
      end
      if (state_q == RUN) begin
         instr_d       = hit ? mem_q[rd_addr] : FILL;
         instr_valid_d = hit;
         fault_d       = fault_q || (!(aligned && in_range) && bus.PC != 32'hFFFF_FFFC);
      end
   end
   // Control and fetch registers; reset drops any partial word and all valid bits
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= LOAD;
         idx_q         <= 2'd0;
         count_q       <= '0;
         valid_q       <= '0;
         part_q        <= '0;
         instr_q       <= FILL;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         count_q       <= count_d;
         valid_q       <= valid_d;
         part_q        <= part_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end
   // Storage array; contents are qualified by valid_q so it needs no reset
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_addr] <= wr_word;
   end
endmodule
